sa_result_drain: RTL and testbench

- Control-and-readout block for an N×N systolic multiply-accumulate array.
- On START, it enables the array's PEs for the number of cycles the skewed operand wavefront needs to reach every PE.
- It then snapshots every PE accumulator and streams the results out one word at a time, row-major, over a valid/ready interface.
- It is the consumer end of the PE accumulator outputs (C). Operand skew feeding and accumulator clearing are outside this block.

---
 rtl/sa_result_drain.sv | 114 +++++++++++
 tb/tb_sa_result_drain.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// Control and readout for an NxN systolic MAC array: runs the PEs for the skewed
// wavefront length, snapshots every accumulator, then streams them out row-major.
module sa_result_drain #(
   parameter int N  = 4,
   parameter int DW = 32,
   parameter int KW = 16
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   START,
   input  logic [KW-1:0]          K,
   output logic                   PE_EN,
   input  logic [N*N*DW-1:0]      C_IN,
   output logic                   OUT_VALID,
   input  logic                   OUT_READY,
   output logic [DW-1:0]          OUT_DATA,
   output logic [$clog2(N)-1:0]   OUT_ROW,
   output logic [$clog2(N)-1:0]   OUT_COL,
   output logic                   OUT_LAST,
   output logic                   BUSY,
   output logic                   DONE
);

   localparam int NW = N * N;
   localparam int IW = $clog2(NW);
   localparam int RW = $clog2(N);
   localparam int CW = KW + 4;
   localparam logic [CW-1:0] SKEW     = CW'(2 * (N - 1));
   localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);
   localparam logic [IW-1:0] N_IDX    = IW'(N);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_SETTLE,
      S_CAPTURE,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [DW-1:0]   snap_q [NW];
   logic [DW-1:0]   snap_d [NW];
   logic            done_q, done_d;
   logic [IW-1:0]   row_w, col_w;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
         for (int i = 0; i < NW; i++) snap_q[i] <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
         for (int i = 0; i < NW; i++) snap_q[i] <= snap_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      for (int i = 0; i < NW; i++) snap_d[i] = snap_q[i];
      case (state_q)
         S_IDLE: begin
            // The counter holds K plus the wavefront skew, so K itself needs no register.
            if (START) begin
               cnt_d   = CW'(K) + SKEW;
               state_d = (K == '0) ? S_SETTLE : S_RUN;
            end
         end
         S_RUN: begin
            if (cnt_q == CW'(1)) state_d = S_SETTLE;
            else                 cnt_d   = cnt_q - CW'(1);
         end
         S_SETTLE: state_d = S_CAPTURE;
         S_CAPTURE: begin
            for (int i = 0; i < NW; i++) snap_d[i] = C_IN[i*DW +: DW];
            idx_d   = '0;
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (OUT_READY) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decode straight from registered state so an async reset drops them at once.
   assign row_w     = idx_q / N_IDX;
   assign col_w     = idx_q % N_IDX;
   assign PE_EN     = (state_q == S_RUN);
   assign OUT_VALID = (state_q == S_DRAIN);
   assign BUSY      = (state_q != S_IDLE);
   assign DONE      = done_q;
   assign OUT_DATA  = snap_q[idx_q];
   assign OUT_ROW   = row_w[RW-1:0];
   assign OUT_COL   = col_w[RW-1:0];
   assign OUT_LAST  = OUT_VALID && (idx_q == LAST_IDX);

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain with N=2: run timing, row-major drain order,
// backpressure, snapshot isolation, async reset and back-to-back runs.
module tb_sa_result_drain;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int KW = 16;
   localparam int NW = N * N;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [KW-1:0]      k = '0;
   logic [NW*DW-1:0]   c_in = '0;
   logic               out_ready = 1'b0;
   logic               pe_en, out_valid, out_last, busy, done;
   logic [DW-1:0]      out_data;
   logic               out_row, out_col;
   logic [34:0]        cur;

   int                 n_tests = 0;
   int                 n_fail  = 0;
   int                 hs_cnt  = 0;
   logic [34:0]        exp_q[$];
   logic [34:0]        prev_word;
   logic               prev_stall = 1'b0;
   logic               ready_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   sa_result_drain #(.N(N), .DW(DW), .KW(KW)) dut (
      .CLK       (clk),
      .RST_N     (rst_n),
      .START     (start),
      .K         (k),
      .PE_EN     (pe_en),
      .C_IN      (c_in),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .OUT_DATA  (out_data),
      .OUT_ROW   (out_row),
      .OUT_COL   (out_col),
      .OUT_LAST  (out_last),
      .BUSY      (busy),
      .DONE      (done)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   assign cur = {out_last, out_row, out_col, out_data};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // scoreboard: every handshake pops one expected word
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && out_valid) check("hold", cur, prev_word);
         if (pe_en && out_valid) check("pe_en_in_drain", 1, 0);
         if (out_valid && out_ready) begin
            hs_cnt <= hs_cnt + 1;
            if (exp_q.size() == 0) check("sb_underflow", 0, 1);
            else                   check("word", cur, exp_q.pop_front());
         end
         prev_stall <= out_valid && !out_ready;
         prev_word  <= cur;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_words(input logic [NW*DW-1:0] c);
      logic [34:0] w;
      for (int i = 0; i < NW; i++) begin
         w = {(i == NW - 1), 1'(i / N), 1'(i % N), c[i*DW +: DW]};
         exp_q.push_back(w);
      end
   endtask

   function automatic logic [NW*DW-1:0] rand_c();
      logic [NW*DW-1:0] c;
      for (int i = 0; i < NW; i++) c[i*DW +: DW] = $urandom();
      return c;
   endfunction

   // mode 0: ready high; 1: ready pattern during drain; 2: corrupt C_IN + stray STARTs
   task automatic do_run(input int kv, input logic [NW*DW-1:0] c, input int mode);
      int runlen   = (kv > 0) ? kv + 2 * (N - 1) : 0;
      int fv_exp   = (kv > 0) ? runlen + 3 : 3;
      int done_exp = fv_exp + ((mode == 1) ? 7 : 4);
      int first_valid = -1;
      int done_at  = -1;
      int pe_cnt   = 0;
      int pe_bad   = 0;
      int busy_bad = 0;
      int done_cnt = 0;
      int busy_after = 0;
      int dcyc     = 0;
      int hs0;
      logic busy_at_done = 1'b1;
      c_in  = c;
      k     = KW'(kv);
      start = 1'b1;
      push_words(c);
      hs0 = hs_cnt;
      step();
      start     = 1'b0;
      k         = '1;
      out_ready = (mode != 1);
      for (int i = 1; i <= 80 && done_at < 0; i++) begin
         if (pe_en) pe_cnt++;
         if (pe_en != (i <= runlen)) pe_bad++;
         if (out_valid && first_valid < 0) first_valid = i;
         if (done) begin
            done_at = i;
            done_cnt++;
            busy_at_done = busy;
         end else if (!busy) begin
            busy_bad++;
         end
         if (mode == 1 && first_valid >= 0) begin
            out_ready = ready_pat[dcyc % 7];
            dcyc++;
         end
         if (mode == 2) begin
            start = (i == 2) || (first_valid == i);
            if (first_valid >= 0) c_in = '1;
         end
         step();
      end
      start     = 1'b0;
      out_ready = 1'b1;
      for (int j = 0; j < 4; j++) begin
         if (done) done_cnt++;
         if (busy) busy_after++;
         step();
      end
      check("done_seen", done_at > 0, 1);
      check("pe_cnt", pe_cnt, runlen);
      check("pe_pattern", pe_bad, 0);
      check("first_valid", first_valid, fv_exp);
      check("done_lat", done_at, done_exp);
      check("words", hs_cnt - hs0, NW);
      check("busy_gap", busy_bad, 0);
      check("busy_at_done", busy_at_done, 0);
      check("done_cnt", done_cnt, 1);
      check("idle_after", busy_after, 0);
      check("sb_empty", exp_q.size(), 0);
   endtask

   initial begin
      logic [NW*DW-1:0] c1;
      int dones, pe_cnt, hs0;
      logic need_pe;

      #1;
      check("rst_pe_en", pe_en, 0);
      check("rst_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_last", out_last, 0);
      check("rst_data", out_data, 0);
      #12 rst_n = 1'b1;
      step();

      c1 = {32'h44, 32'h33, 32'h22, 32'h11};
      do_run(3, c1, 0);
      do_run(3, rand_c(), 1);
      do_run(0, rand_c(), 0);
      do_run(3, rand_c(), 2);

      // async reset mid-RUN
      start = 1'b1;
      k     = 16'd3;
      step();
      start = 1'b0;
      step();
      check("pre_rst_run_pe", pe_en, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_run_pe", pe_en, 0);
      check("rst_run_busy", busy, 0);
      check("rst_run_done", done, 0);
      step();
      #3 rst_n = 1'b1;
      step();

      // async reset mid-DRAIN under backpressure
      out_ready = 1'b0;
      c_in  = rand_c();
      start = 1'b1;
      k     = 16'd0;
      step();
      start = 1'b0;
      step();
      step();
      check("pre_rst_drain_valid", out_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_drain_valid", out_valid, 0);
      check("rst_drain_busy", busy, 0);
      check("rst_drain_pe", pe_en, 0);
      check("rst_drain_done", done, 0);
      step();
      #3 rst_n = 1'b1;
      step();
      do_run(2, rand_c(), 0);

      // START held high: back-to-back runs with K=1
      c1 = rand_c();
      push_words(c1);
      push_words(c1);
      c_in      = c1;
      out_ready = 1'b1;
      k         = 16'd1;
      start     = 1'b1;
      hs0       = hs_cnt;
      dones     = 0;
      pe_cnt    = 0;
      need_pe   = 1'b0;
      step();
      for (int i = 1; i <= 60 && dones < 2; i++) begin
         if (pe_en) pe_cnt++;
         if (need_pe) begin
            check("b2b_restart", pe_en, 1);
            need_pe = 1'b0;
         end
         if (done) begin
            dones++;
            if (dones == 1) need_pe = 1'b1;
            else            start   = 1'b0;
         end
         step();
      end
      start = 1'b0;
      step();
      step();
      check("b2b_dones", dones, 2);
      check("b2b_pe_cnt", pe_cnt, 6);
      check("b2b_words", hs_cnt - hs0, 2 * NW);
      check("b2b_sb_empty", exp_q.size(), 0);
      check("b2b_idle", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
